// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_pkg
// Brief    : Shared types, default widths and sel clamping helper for the
//            stream_demux 1:N packet router.
// Revision : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

  localparam int DEF_N_OUT = 4;
  localparam int DEF_DW    = 8;

  // DROP is reachable only when DEMUX_ERR_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  // Out-of-range selects collapse onto the highest channel.
  function automatic int clamp_sel(input int sel, input int n_out);
    return (sel >= n_out) ? (n_out - 1) : sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot
// Brief    : One-entry output register stage for a single demux channel.
//            Can load and drain in the same cycle; free tells the router
//            whether a new beat may be written this cycle.
// Revision : 1.0 - initial release
// ============================================================================
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          lin,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          free
);

  assign free = !m_valid | m_ready;

  // Hold the beat until the consumer takes it; data/last only change on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= din;
        m_last  <= lin;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux
// Brief    : Routes one valid/ready byte stream to one of N_OUT registered
//            output channels. The destination is taken from sel on the first
//            beat of a packet and held until the beat carrying last.
//            Optional macro DEMUX_ERR_EN: out-of-range sel drops the packet
//            and pulses err instead of clamping to channel N_OUT-1.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_OUT = DEF_N_OUT,
  parameter int DW    = DEF_DW,
  parameter int SELW  = $clog2(N_OUT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  input  logic [SELW-1:0]     sel,
  output logic [N_OUT*DW-1:0] m_data,
  output logic [N_OUT-1:0]    m_valid,
  output logic [N_OUT-1:0]    m_last,
  input  logic [N_OUT-1:0]    m_ready
`ifdef DEMUX_ERR_EN
  ,
  output logic                err
`endif
);

  state_t            r_state;
  logic [SELW-1:0]   r_lock_ch;
  logic [SELW-1:0]   w_tgt;
  logic [N_OUT-1:0]  w_free;
  logic [N_OUT-1:0]  w_load;
  logic              w_drop;
  logic              w_acc;
  logic              w_write;

  // Current target: live (clamped) sel on a first beat, locked channel after.
  always_comb begin
    w_tgt = r_lock_ch;
    if (r_state == IDLE) begin
      w_tgt = SELW'(clamp_sel(int'(sel), N_OUT));
    end
  end

`ifdef DEMUX_ERR_EN
  logic w_bad;
  assign w_bad  = (r_state == IDLE) && (int'(sel) >= N_OUT);
  assign w_drop = w_bad || (r_state == DROP);
`else
  assign w_drop = 1'b0;
`endif

  // Dropped beats are swallowed unconditionally; otherwise follow the target slot.
  assign s_ready = w_drop | w_free[w_tgt];
  assign w_acc   = s_valid & s_ready;
  assign w_write = w_acc & ~w_drop;

  // Packet framing FSM: lock the channel on a multi-beat first beat, release on last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lock_ch <= '0;
`ifdef DEMUX_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
`ifdef DEMUX_ERR_EN
      err <= w_acc & w_bad;
`endif
      case (r_state)
        IDLE: begin
          if (w_acc && !s_last) begin
            r_lock_ch <= w_tgt;
            r_state   <= w_drop ? DROP : ROUTE;
          end
        end
        ROUTE, DROP: begin
          if (w_acc && s_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    assign w_load[i] = w_write && (w_tgt == SELW'(i));

    demux_slot #(
      .DW (DW)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (w_load[i]),
      .din     (s_data),
      .lin     (s_last),
      .m_valid (m_valid[i]),
      .m_ready (m_ready[i]),
      .m_data  (m_data[i*DW +: DW]),
      .m_last  (m_last[i]),
      .free    (w_free[i])
    );
  end

endmodule
`default_nettype wire

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Routes one valid/ready byte stream to one of N_OUT output streams. It is the receive-side counterpart of the team's 2:1/N:1 select muxes: one source is fanned out to many sinks.
- The destination is chosen per packet. sel is sampled on the first beat and held until the beat carrying last.
- Each output has a one-entry register stage, so outputs are registered and latency is fixed at one cycle.
- Sits between a packet source and per-channel consumers, such as per-port TX FIFOs.

Parameters:
- N_OUT, 4, number of output channels (2..16).
- DW, 8, data width per beat.
- SELW, $clog2(N_OUT), width of sel (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DW  input beat data.
- s_valid  in  1  input beat valid.
- s_last  in  1  marks the final beat of a packet.
- s_ready  out  1  input accepted when s_valid & s_ready.
- sel  in  SELW  destination channel; sampled only on the first beat of a packet.
- m_data  out  N_OUT*DW  per-channel data; channel i occupies bits [i*DW +: DW].
- m_valid  out  N_OUT  per-channel valid.
- m_last  out  N_OUT  per-channel last.
- m_ready  in  N_OUT  per-channel ready.
- err  out  1  one-cycle pulse for an out-of-range sel; only exists with DEMUX_ERR_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, lock_ch=0, all m_valid=0, m_data=0, m_last=0, err=0. Any packet in flight is abandoned and any buffered beats are discarded.
- FSM states: IDLE and ROUTE.
  - IDLE: target channel is sel. An accepted beat with s_last=0 latches lock_ch=sel and moves to ROUTE. An accepted beat with s_last=1 (single-beat packet) stays in IDLE.
  - ROUTE: target channel is lock_ch and sel is ignored. An accepted beat with s_last=1 returns to IDLE.
  - No other transitions.
- Per-channel register slot i:
  - Empty: m_valid[i]=0.
  - Loaded on an accepted beat targeting i: m_data[i], m_last[i] and m_valid[i]=1 take effect the cycle after the handshake, giving 1-cycle latency.
  - Drains when m_valid[i] & m_ready[i].
- s_ready = !m_valid[t] | m_ready[t], where t is the current target. This allows a load and a drain on the same cycle, so one beat per cycle is sustained while the consumer is ready.
- s_ready depends combinationally on sel (in IDLE) and on m_ready[t]. There is no combinational path from s_valid to s_ready.
- Non-target channels never change because of input traffic; they drain independently.
- Consecutive packets to different channels can be accepted on back-to-back cycles. The previous channel's slot drains in parallel.
- Once m_valid is high, m_data and m_last stay stable until the handshake completes.
- Out-of-range sel (sel >= N_OUT, only possible when N_OUT is not a power of 2): clamped to channel N_OUT-1, unless DEMUX_ERR_EN is defined.
- sel changing mid-packet has no effect.
- s_valid may drop between beats. The FSM stays in ROUTE indefinitely.

Optional Feature:
- Macro: DEMUX_ERR_EN.
- Defined:
  - In IDLE, a first beat with sel >= N_OUT is accepted with s_ready=1 regardless of outputs.
  - err pulses high for 1 cycle after that beat.
  - The FSM enters state DROP, which consumes beats with s_ready=1 and writes no channel.
  - DROP exits to IDLE on an accepted s_last. A single-beat bad packet stays in IDLE.
  - The err port exists.
- Undefined: no DROP state, no err port, and the clamp rule applies.

Decomposition:
- Package stream_demux_pkg holds:
  - state enum {IDLE, ROUTE, DROP}.
  - Function clamp_sel(sel, N_OUT).
  - Localparam default widths.
- Sub-module demux_slot: one-entry register stage, generated N_OUT times.
  - Ports: clk, rst_n, load, din, lin, m_valid, m_ready, m_data, m_last.
  - Exposes a free signal = !m_valid | m_ready.

Test Plan:
- Single-beat packets, all m_ready=1, sel=2 with s_data=0xA5 and s_last=1 -> next cycle m_valid=4'b0100 and m_data[23:16]=0xA5; other channels stay idle.
- 3-beat packet 0x11, 0x22, 0x33 with sel=1 on beat 0 and sel=3 on beats 1-2 -> all three beats appear on channel 1 in order, m_last on 0x33 only; channel 3 untouched.
- Backpressure: m_ready[0]=0, two beats sent to channel 0 -> first beat buffered and s_ready=0 on the second. Raise m_ready[0] -> both delivered with no loss or duplication and data held stable while stalled.
- Back-to-back packets: 1-beat packet to channel 0 then 1-beat packet to channel 3, with m_ready[0]=0 -> second packet accepted next cycle and appears on channel 3 while channel 0 holds.
- Reset mid-packet: assert rst_n=0 after beat 1 of a 4-beat packet to channel 2 -> all m_valid=0 immediately. After release, a new packet with sel=0 routes to channel 0.
- N_OUT=3: DEMUX_ERR_EN defined, 2-beat packet with sel=3 -> err pulses once, both beats consumed, no m_valid. Undefined, same stimulus -> packet delivered on channel 2.
